reg_write_arbiter: RTL and testbench
====================================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, write-data width.
REQ-002 Parameter NUM_REGS, default 15, number of writable registers; addresses 1..NUM_REGS; address 0 is never written.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  begins or restarts a write sequence.
REQ-006 req0, req1  input  1 each  write request from requester 0 / 1; held with data stable until granted.
REQ-007 data0, data1  input  DATA_W each  write data of requester 0 / 1.
REQ-008 gnt0, gnt1  output  1 each  combinational grant; transfer occurs on the edge where reqN and gntN are both high.
REQ-009 we  output  1  registered register-file write enable.
REQ-010 waddr  output  4  registered register-file write address.
REQ-011 wdata  output  DATA_W  registered register-file write data.
REQ-012 busy  output  1  high while in RUN.
REQ-013 done  output  1  sequence-complete indication (see REQ-025, REQ-026).

Function
REQ-014 FSM states IDLE, RUN, DONE; encoding is implementation choice.
REQ-015 IDLE: start=1 -> RUN, next address loaded with 1; otherwise stay.
REQ-016 RUN: start is ignored; the sequence continues.
REQ-017 gnt0/gnt1 are 0 outside RUN; at most one grant is high per cycle.
REQ-018 RUN, single requester active: that requester is granted the same cycle.
REQ-019 RUN, both requesting: round-robin; grant goes to the requester not granted last; after reset the priority pointer favours requester 0.
REQ-020 Priority pointer updates only on an actual transfer.
REQ-021 On a transfer edge: we=1, waddr=current next-address, wdata=granted requester's data, all visible the following cycle (latency 1); we=0 in every cycle without a preceding transfer.
REQ-022 Next-address increments by 1 after each transfer; waddr holds its last value when we=0.
REQ-023 Exactly one register-file write per granted transfer; no write is generated without a grant.

Reset
REQ-024 rst=1 at a clock edge: state IDLE, next-address 1, priority pointer to requester 0, we=0, waddr=0, wdata=0, busy=0, done=0, grants 0 from the next cycle; rst overrides start and in-flight transfers, and the transfer on that edge is dropped.

Configuration
REQ-025 Macro WRITE_WRAP_EN defined: after the transfer to address NUM_REGS, next-address wraps to 1 and the FSM stays in RUN; done pulses high for one cycle, coincident with we for address NUM_REGS; DONE state is unreachable.
REQ-026 WRITE_WRAP_EN undefined: after the transfer to address NUM_REGS, FSM -> DONE; done=1 while in DONE; grants are 0; start=1 in DONE -> RUN with next-address 1 and done cleared the next cycle.

Verification
REQ-027 rst=1, 2 cycles -> we=0, waddr=0, wdata=0, busy=0, done=0, gnt0=gnt1=0.
REQ-028 start pulse, then req0 with data0=0x00AA held 1 cycle -> gnt0=1 in that cycle; next cycle we=1, waddr=1, wdata=0x00AA; busy=1.
REQ-029 RUN, req0=req1=1 continuously, data0=0x1111, data1=0x2222 -> grants alternate 0,1,0,1; writes to addr 1,2,3,4 with data 0x1111,0x2222,0x1111,0x2222.
REQ-030 RUN, 15 back-to-back req1 transfers: WRITE_WRAP_EN defined -> 16th writes addr 1, done pulses with addr 15; undefined -> DONE after addr 15, done=1, 16th request gets no grant and no we.
REQ-031 rst=1 asserted mid-sequence at next-address 7 with req0=1 -> no write on that edge, we=0 after; after start, the next write goes to addr 1.
REQ-032 RUN, start pulsed with req0=1 -> start ignored; write sequence continues at the current address without reset to 1.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Two-requester round-robin arbiter that turns granted requests into sequential register-file writes.
// Define WRITE_WRAP_EN to wrap the write address back to 1 (with a done pulse) instead of stopping in DONE.
module reg_write_arbiter #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              we,
  output logic [3:0]        waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] LAST_ADDR = 4'(NUM_REGS);

  state_t     state;
  state_t     nextState;
  logic [3:0] nextAddr;
  logic       prioPtr;
  logic       transfer;
  logic       lastXfer;

  assign transfer = gnt0 | gnt1;
  assign lastXfer = (nextAddr == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (start) nextState = RUN;
      RUN: begin
`ifndef WRITE_WRAP_EN
        if (transfer && lastXfer) nextState = DONE;
`endif
      end
      DONE: if (start) nextState = RUN;
      default: nextState = IDLE;
    endcase
  end

  // prioPtr set means requester 1 wins the next tie.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    busy = 1'b0;
    if (state == RUN) begin
      busy = 1'b1;
      gnt0 = req0 & (~req1 | ~prioPtr);
      gnt1 = req1 & (~req0 | prioPtr);
    end
  end

`ifdef WRITE_WRAP_EN
  logic donePulse;
  assign done = donePulse;
`else
  assign done = (state == DONE);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      nextAddr <= 4'd1;
      prioPtr  <= 1'b0;
      we       <= 1'b0;
      waddr    <= 4'd0;
      wdata    <= '0;
`ifdef WRITE_WRAP_EN
      donePulse <= 1'b0;
`endif
    end else begin
      we <= transfer;
`ifdef WRITE_WRAP_EN
      donePulse <= transfer & lastXfer;
`endif
      if (transfer) begin
        waddr    <= nextAddr;
        wdata    <= gnt1 ? data1 : data0;
        prioPtr  <= gnt0;
        nextAddr <= lastXfer ? 4'd1 : nextAddr + 4'd1;
      end
      // A new sequence always restarts at the first register.
      if ((state == IDLE || state == DONE) && start) nextAddr <= 4'd1;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Randomized self-checking bench for reg_write_arbiter against a behavioural sequence model.
// Follows the DUT's WRITE_WRAP_EN setting when the macro is defined for both.
module tb_reg_write_arbiter;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 15;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic              clk = 1'b0;
  logic              rst, start, req0, req1;
  logic [DATA_W-1:0] data0, data1;
  logic              gnt0, gnt1, we, busy, done;
  logic [3:0]        waddr;
  logic [DATA_W-1:0] wdata;

  int errors = 0;
  int checks = 0;

  // Model: sequence phase, address of the next write, who was granted last, and the registered outputs expected now.
  int  mState = M_IDLE;
  int  mNext = 1;
  int  mLast = 1;
  bit  mValid = 0;
  bit  expWe = 0;
  bit  expDone = 0;
  bit  wdataCheck = 0;
  int  expAddr = 0;
  int  expData = 0;

  reg_write_arbiter #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .rst(rst), .start(start), .req0(req0), .req1(req1),
    .data0(data0), .data1(data1), .gnt0(gnt0), .gnt1(gnt1), .we(we),
    .waddr(waddr), .wdata(wdata), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drives one cycle of inputs, checks the DUT against the model, then advances the model across the clock edge.
  task automatic applyStimulus(input bit st, input bit r0, input bit r1,
                               input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                               input bit rs, output bit g0, output bit g1);
    int s0;
    bit lastWrite;
    start = st; req0 = r0; req1 = r1; data0 = d0; data1 = d1; rst = rs;
    #1;
    g0 = 0; g1 = 0;
    if (mState == M_RUN) begin
      if (r0 && r1) begin
        if (mLast == 0) g1 = 1; else g0 = 1;
      end else begin
        g0 = r0; g1 = r1;
      end
    end
    if (mValid) begin
      checkOutput("gnt0", {31'd0, gnt0}, {31'd0, g0});
      checkOutput("gnt1", {31'd0, gnt1}, {31'd0, g1});
      checkOutput("busy", {31'd0, busy}, (mState == M_RUN) ? 32'd1 : 32'd0);
      checkOutput("we", {31'd0, we}, {31'd0, expWe});
      checkOutput("done", {31'd0, done}, {31'd0, expDone});
      checkOutput("waddr", {28'd0, waddr}, expAddr);
      if (wdataCheck) checkOutput("wdata", {16'd0, wdata}, expData);
    end
    s0 = mState;
    if (rs) begin
      mState = M_IDLE; mNext = 1; mLast = 1; mValid = 1;
      expWe = 0; expDone = 0; expAddr = 0; expData = 0; wdataCheck = 1;
    end else begin
      lastWrite = (g0 || g1) && (mNext == NUM_REGS);
      if (g0 || g1) begin
        expWe = 1; expAddr = mNext; expData = g1 ? d1 : d0; wdataCheck = 1;
        mLast = g1 ? 1 : 0;
        mNext = lastWrite ? 1 : mNext + 1;
`ifndef WRITE_WRAP_EN
        if (lastWrite) mState = M_DONE;
`endif
      end else begin
        expWe = 0; wdataCheck = 0;
      end
      if (s0 != M_RUN && st) begin
        mState = M_RUN; mNext = 1;
      end
`ifdef WRITE_WRAP_EN
      expDone = lastWrite;
`else
      expDone = (mState == M_DONE);
`endif
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    bit g0, g1, hr0, hr1, rs, st;
    logic [DATA_W-1:0] hd0, hd1;
    rst = 1; start = 0; req0 = 0; req1 = 0; data0 = '0; data1 = '0;

    // Reset held two cycles, then one quiet idle cycle.
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 1, g0, g1);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 1, g0, g1);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, g0, g1);

    // Single write from requester 0.
    applyStimulus(1, 0, 0, 16'h0, 16'h0, 0, g0, g1);
    applyStimulus(0, 1, 0, 16'h00AA, 16'h0, 0, g0, g1);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, g0, g1);

    // Both requesting: alternation.
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 16'h1111, 16'h2222, 0, g0, g1);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, g0, g1);

    // Back-to-back requester 1 through the last address and beyond, then restart from DONE.
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 1, g0, g1);
    applyStimulus(1, 0, 0, 16'h0, 16'h0, 0, g0, g1);
    for (int i = 0; i < 17; i++) applyStimulus(0, 0, 1, 16'h0, 16'(16'h0B00 + i), 0, g0, g1);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, g0, g1);
    applyStimulus(1, 0, 0, 16'h0, 16'h0, 0, g0, g1);
    applyStimulus(0, 1, 0, 16'h0C0C, 16'h0, 0, g0, g1);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, g0, g1);

    // Reset in mid-sequence with a live request, then restart.
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 1, g0, g1);
    applyStimulus(1, 0, 0, 16'h0, 16'h0, 0, g0, g1);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 16'(16'h0D00 + i), 16'h0, 0, g0, g1);
    applyStimulus(0, 1, 0, 16'h0DDD, 16'h0, 1, g0, g1);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, g0, g1);
    applyStimulus(1, 0, 0, 16'h0, 16'h0, 0, g0, g1);
    applyStimulus(0, 1, 0, 16'h0E0E, 16'h0, 0, g0, g1);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, g0, g1);

    // Start pulsed while running must not restart addressing.
    applyStimulus(0, 1, 0, 16'h0F01, 16'h0, 0, g0, g1);
    applyStimulus(1, 1, 0, 16'h0F02, 16'h0, 0, g0, g1);
    applyStimulus(0, 1, 0, 16'h0F03, 16'h0, 0, g0, g1);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, g0, g1);

    // Random traffic: requests are held with stable data until granted.
    hr0 = 0; hr1 = 0; hd0 = '0; hd1 = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!hr0) begin hr0 = ($urandom_range(0, 2) != 0); hd0 = 16'($urandom); end
      if (!hr1) begin hr1 = ($urandom_range(0, 2) != 0); hd1 = 16'($urandom); end
      rs = ($urandom_range(0, 149) == 0);
      st = ($urandom_range(0, 7) == 0);
      applyStimulus(st, hr0, hr1, hd0, hd1, rs, g0, g1);
      if (g0 || rs) hr0 = 0;
      if (g1 || rs) hr1 = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
